// File: rtl/data_bus_responder.sv
// Data-bus target for the multicycle core: byte-lane RAM plus a 64-bit timer MMIO window.
// Read data is registered one cycle after the request, and bad accesses latch a sticky error flag.
module data_bus_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFF20_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic [3:0]  iByteEnable,
    input  logic        iWriteEnable,
    input  logic        iReadEnable,
    output logic [31:0] oReadData,
    output logic        oTimerIRQ,
    output logic        oBusError
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {
        REG_CNT_LO = 2'd0,
        REG_CNT_HI = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

    logic [31:0] r_mem [RAM_WORDS];
    logic [63:0] r_counter;
    logic [31:0] r_hi_snap;
    logic [31:0] r_cmp;
    logic        r_match;
    logic        r_irq_en;
    logic        r_irq;
    logic        r_bus_error;
    logic [31:0] r_read_data;

    logic [31:0] w_ram_off;
    logic [31:0] w_mmio_off;
    logic        w_ram_hit;
    logic        w_mmio_hit;
    logic [AW-1:0] w_ram_idx;
    mmio_reg_e   w_mmio_sel;
    logic        w_mmio_wr_ok;
    logic        w_access_err;
    logic        w_status_w1c;
    logic        w_match_next;
    logic [31:0] w_mmio_rdata;

    // Full-width offsets keep every address bit in the decode; the windows are word-aligned,
    // so iAddress[1:0] never changes the outcome.
    assign w_ram_off  = iAddress - RAM_BASE;
    assign w_mmio_off = iAddress - MMIO_BASE;
    assign w_ram_hit  = (iAddress >= RAM_BASE) && (w_ram_off < RAM_BYTES);
    assign w_mmio_hit = (iAddress >= MMIO_BASE) && (w_mmio_off < 32'd16);
    assign w_ram_idx  = w_ram_off[AW+1:2];
    assign w_mmio_sel = mmio_reg_e'(w_mmio_off[3:2]);

    assign w_mmio_wr_ok = iWriteEnable && w_mmio_hit && (iByteEnable == 4'hF);
    assign w_access_err = ((iWriteEnable || iReadEnable) && !w_ram_hit && !w_mmio_hit)
                       || (iWriteEnable && w_mmio_hit && (iByteEnable != 4'hF));

    // A compare hit in the same cycle as a W1C keeps MATCH set.
    assign w_status_w1c = w_mmio_wr_ok && (w_mmio_sel == REG_STATUS) && iWriteData[0];
    assign w_match_next = (r_counter[31:0] == r_cmp) || (r_match && !w_status_w1c);

    always_comb begin
        w_mmio_rdata = '0;
        case (w_mmio_sel)
            REG_CNT_LO: w_mmio_rdata = r_counter[31:0];
            REG_CNT_HI: w_mmio_rdata = r_hi_snap;
            REG_CMP:    w_mmio_rdata = r_cmp;
            REG_STATUS: w_mmio_rdata = {30'd0, r_irq_en, r_match};
            default:    w_mmio_rdata = '0;
        endcase
    end

    // NOTE: the RAM array has no reset and lives in its own block so it maps onto block RAM;
    // only the write is gated by reset, which is what preserves contents across iRST.
    always_ff @(posedge iCLK) begin
        if (!iRST && iWriteEnable && w_ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (iByteEnable[b]) r_mem[w_ram_idx][8*b +: 8] <= iWriteData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_counter   <= '0;
            r_hi_snap   <= '0;
            r_cmp       <= 32'hFFFF_FFFF;
            r_match     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
            r_bus_error <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_counter <= r_counter + 64'd1;
            // Reading the old array entry here gives read-first behaviour on a same-word write.
            if (iReadEnable) begin
                if (w_ram_hit)       r_read_data <= r_mem[w_ram_idx];
                else if (w_mmio_hit) r_read_data <= w_mmio_rdata;
                else                 r_read_data <= '0;
            end
            if (iReadEnable && w_mmio_hit && (w_mmio_sel == REG_CNT_LO))
                r_hi_snap <= r_counter[63:32];
            if (w_mmio_wr_ok && (w_mmio_sel == REG_CMP))    r_cmp    <= iWriteData;
            if (w_mmio_wr_ok && (w_mmio_sel == REG_STATUS)) r_irq_en <= iWriteData[1];
            r_match <= w_match_next;
            r_irq   <= r_match && r_irq_en;
            if (w_access_err) r_bus_error <= 1'b1;
        end
    end

    assign oReadData = r_read_data;
    assign oTimerIRQ = r_irq;
    assign oBusError = r_bus_error;
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-mapped responder on the datapath's data bus: the target end of the address/write-data/read-data/byte-enable interface the multicycle core drives. It serves a byte-addressable data RAM and a small timer MMIO window, returns registered read data, and flags unmapped or illegal accesses. Writes commit on the clock edge; read data is presented one cycle after the request.

## Interface
- RAM_BASE, 32'h1001_0000, byte base address of the data RAM window.
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'hFF20_0000, byte base of the 16-byte timer window.
- iCLK  in  1  system clock; all state changes on its rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iAddress  in  32  byte address from the core.
- iWriteData  in  32  write data, already lane-aligned by the core.
- iByteEnable  in  4  per-byte write strobes; bit n gates bits [8n+7:8n].
- iWriteEnable  in  1  write request, sampled each cycle.
- iReadEnable  in  1  read request, sampled each cycle.
- oReadData  out  32  registered read data.
- oTimerIRQ  out  1  registered timer interrupt request.
- oBusError  out  1  sticky access-error flag.

## Operation
- Decode uses iAddress[31:2]. Bits [1:0] are ignored.
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE + 16.
  - Anything else is unmapped.
- RAM write, when iWriteEnable is high and the address hits RAM:
  - Each byte is written only where its iByteEnable bit is 1.
  - iByteEnable = 0 writes nothing and is not an error.
- RAM read is read-first. With iReadEnable and iWriteEnable both high on the same word, oReadData returns the pre-write contents.
- MMIO registers (offset from MMIO_BASE):
  - 0x0 CNT_LO (RO): counter[31:0]. Reading it also snapshots counter[63:32] into HI_SNAP.
  - 0x4 CNT_HI (RO): returns HI_SNAP, giving an atomic 64-bit read as LO then HI.
  - 0x8 CMP (RW): compare value; reset value 32'hFFFF_FFFF.
  - 0xC STATUS: bit0 MATCH (write-1-to-clear), bit1 IRQ_EN (RW); bits [31:2] read 0.
- Counter: 64-bit, increments by 1 every cycle not in reset, wraps from 2^64-1 to 0.
- MATCH is set in any cycle where counter[31:0] == CMP. If set and a W1C land in the same cycle, set wins.
- oTimerIRQ is registered MATCH & IRQ_EN.
- MMIO writes take effect only when iByteEnable == 4'hF.
  - Writes to RO registers are ignored without error.
  - A partial-strobe MMIO write is ignored and sets oBusError.
- Unmapped access:
  - Read returns 0.
  - Write is ignored.
  - Either one sets oBusError.
  - oBusError stays high until reset.
- With iReadEnable low, oReadData holds its previous value.

## Timing
- Reset: on a rising edge with iRST high:
  - oReadData, oTimerIRQ, oBusError, counter, HI_SNAP and STATUS all become 0.
  - CMP becomes 32'hFFFF_FFFF.
  - RAM contents are preserved.
- Reset asserted mid-access wins: the write in that cycle is discarded and oReadData becomes 0.
- Read latency is 1 cycle. A request sampled at edge N drives oReadData after edge N; it is valid for the core's capture at edge N+1. The core holds iReadEnable and the address for two cycles per load.
- A CNT_LO read sampled at edge N returns the counter value held before edge N. That edge is also when HI_SNAP is captured.
- Write-then-read of the same RAM word in consecutive cycles returns the new data; no bypass is needed.
- MATCH is visible in STATUS reads one cycle after the compare condition holds.
- oTimerIRQ follows MATCH & IRQ_EN with one further cycle of delay.
- oBusError rises on the edge that samples the offending access.

## Test plan
- Byte lanes: write 32'hDEADBEEF to RAM_BASE+8 with strobe F, then 32'h0000_5500 with strobe 4'b0010. A read of RAM_BASE+8 must return 32'hDEAD55EF one cycle later.
- Read-first: assert read and write of 32'h1234_5678 together on a word holding 32'hA5A5_A5A5. oReadData must be 32'hA5A5_A5A5; the following read must return 32'h1234_5678.
- Counter atomicity: force the counter near 32'hFFFF_FFFF low. Read CNT_LO, wait several cycles across the wrap, then read CNT_HI. CNT_HI must equal the high word at the time of the LO read, not the incremented value.
- Timer IRQ:
  - Write CMP = 20 and STATUS = 2, then reach counter low = 20. MATCH must set and oTimerIRQ must assert one cycle later.
  - Write STATUS = 3 in the match cycle: MATCH must stay 1 (set wins).
  - Write STATUS = 3 later: oTimerIRQ must drop.
- Errors: a read at 32'h0000_0000 returns 0 and sets oBusError. A byte write to MMIO_BASE+8 leaves CMP unchanged and oBusError stays 1. iRST clears oBusError.
- Reset mid-write: a RAM write with iRST high must leave the old word intact, and oReadData must be 0 after that edge.
